// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: owns the access side of the 32x32 MIPS register file for
// the multi-cycle datapath. It takes one instruction at a time, reads both
// source operands with $0 forced to zero, and hands them to execute. It then
// waits for the result and writes it back, suppressing writes to $0 and
// writes from non-writing instructions.
//
// Ports:
//   CLK, RST                        clock (rising edge), async active-high reset
//   issue_valid/issue_ready         instruction handshake
//   issue_rs/rt/rd, issue_wen       instruction register fields, writeback flag
//   ra, rb / busA, busB             register file read addresses / read data
//   rw, busW, ew                    register file write address / data / enable
//   op_valid/op_ready, opA, opB     operand handshake to execute
//   res_valid/res_ready, res_data   result handshake from execute
//   retire_cnt                      completed-instruction count (wraps)
//   busy                            high whenever not idle
module rf_access_ctrl #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic [4:0]       issue_rd,
    input  logic             issue_wen,
    output logic [4:0]       ra,
    output logic [4:0]       rb,
    input  logic [DW-1:0]    busA,
    input  logic [DW-1:0]    busB,
    output logic [4:0]       rw,
    output logic [DW-1:0]    busW,
    output logic             ew,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [DW-1:0]    opA,
    output logic [DW-1:0]    opB,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [DW-1:0]    res_data,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        OPER,
        WAIT_RES,
        WRITE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [4:0] rd_q;
    logic       wen_q;
    logic       do_write;

    // A result only reaches the register file if the instruction writes and
    // its destination is not $0.
    assign do_write    = wen_q && (rd_q != 5'd0);
    assign issue_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (issue_valid) next_state = FETCH;
            FETCH:    next_state = OPER;
            OPER:     if (op_ready) next_state = WAIT_RES;
            WAIT_RES: if (res_valid) next_state = do_write ? WRITE : IDLE;
            WRITE:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ra         <= '0;
            rb         <= '0;
            rw         <= '0;
            busW       <= '0;
            ew         <= 1'b0;
            op_valid   <= 1'b0;
            opA        <= '0;
            opB        <= '0;
            res_ready  <= 1'b0;
            retire_cnt <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        ra    <= issue_rs;
                        rb    <= issue_rt;
                        rd_q  <= issue_rd;
                        wen_q <= issue_wen;
                    end
                end
                FETCH: begin
                    // $0 reads as zero regardless of what the file returns.
                    opA      <= (ra == 5'd0) ? '0 : busA;
                    opB      <= (rb == 5'd0) ? '0 : busB;
                    op_valid <= 1'b1;
                end
                OPER: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        res_ready <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        res_ready <= 1'b0;
                        if (do_write) begin
                            rw   <= rd_q;
                            busW <= res_data;
                            ew   <= 1'b1;
                        end else begin
                            retire_cnt <= retire_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    ew         <= 1'b0;
                    retire_cnt <= retire_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
module tb_rf_access_ctrl;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          CLK;
    logic          RST;
    logic          issue_valid;
    logic          issue_ready;
    logic [4:0]    issue_rs, issue_rt, issue_rd;
    logic          issue_wen;
    logic [4:0]    ra, rb, rw;
    logic [DW-1:0] busA, busB, busW;
    logic          ew;
    logic          op_valid, op_ready;
    logic [DW-1:0] opA, opB;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic [CW-1:0] retire_cnt;
    logic          busy;

    rf_access_ctrl #(.DW(DW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_wen(issue_wen),
        .ra(ra), .rb(rb), .busA(busA), .busB(busB),
        .rw(rw), .busW(busW), .ew(ew),
        .op_valid(op_valid), .op_ready(op_ready), .opA(opA), .opB(opB),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .retire_cnt(retire_cnt), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment register file. Entry 0 holds all-ones so the DUT's $0
    // forcing is actually exercised.
    logic [DW-1:0] rf_mem [32];
    logic          init_done = 1'b0;
    int unsigned   ew_total = 0;
    logic [4:0]    last_rw = '0;
    logic [DW-1:0] last_busW = '0;
    int unsigned   cyc = 0;

    assign busA = rf_mem[ra];
    assign busB = rf_mem[rb];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
            rf_mem[0] = '1;
            init_done = 1'b1;
        end
        if (ew) begin
            ew_total  = ew_total + 1;
            last_rw   = rw;
            last_busW = busW;
            rf_mem[rw] = busW;
        end
    end

    // Reference model: architectural register values and retired count.
    logic [DW-1:0] ref_rf [32];
    int unsigned   ref_cnt;
    int unsigned   checks = 0;
    int unsigned   errors = 0;

    function automatic logic [DW-1:0] ref_read(input logic [4:0] r);
        return (r == 5'd0) ? '0 : ref_rf[r];
    endfunction

    // Model of one completed instruction's architectural effect.
    task automatic ref_retire(input logic [4:0] rd, input logic wen, input logic [DW-1:0] res);
        if (wen && rd != 5'd0) ref_rf[rd] = res;
        ref_cnt = (ref_cnt + 1) % (1 << CW);
    endtask

    // Drives one instruction through the handshakes and reports observations.
    task automatic do_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic wen, input logic [DW-1:0] res,
                            input int unsigned op_wait, input int unsigned res_wait,
                            output logic [DW-1:0] o_a, output logic [DW-1:0] o_b,
                            output int unsigned o_ew, output int unsigned o_lat,
                            output logic to);
        int unsigned ew0, acc, n;
        to = 1'b0;
        @(negedge CLK);
        n = 0;
        while (!issue_ready && n < 20) begin @(negedge CLK); n++; end
        if (!issue_ready) to = 1'b1;
        ew0 = ew_total;
        issue_valid = 1'b1; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_wen = wen;
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        acc = cyc;
        @(negedge CLK);
        n = 0;
        while (!op_valid && n < 20) begin @(negedge CLK); n++; end
        if (!op_valid) to = 1'b1;
        repeat (op_wait) @(negedge CLK);
        o_a = opA; o_b = opB;
        op_ready = 1'b1;
        @(posedge CLK); #1;
        op_ready = 1'b0;
        @(negedge CLK);
        n = 0;
        while (!res_ready && n < 20) begin @(negedge CLK); n++; end
        if (!res_ready) to = 1'b1;
        repeat (res_wait) @(negedge CLK);
        res_valid = 1'b1; res_data = res;
        @(posedge CLK); #1;
        res_valid = 1'b0;
        @(negedge CLK);
        n = 0;
        while (busy && n < 20) begin @(negedge CLK); n++; end
        if (busy) to = 1'b1;
        o_lat = cyc - acc;
        o_ew  = ew_total - ew0;
    endtask

    task automatic test_reset;
        logic [DW-1:0] a, b;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        ref_cnt = 0;
        @(negedge CLK);
        checks++;
        if (issue_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: issue_ready=%b busy=%b, want 1/0", issue_ready, busy);
        end
        // Get into OPER with nonzero outputs, then reset between edges.
        issue_valid = 1'b1; issue_rs = 5'd3; issue_rt = 5'd4; issue_rd = 5'd6; issue_wen = 1'b1;
        @(posedge CLK); #1 issue_valid = 1'b0;
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (op_valid !== 1'b1) begin
            errors++; $display("FAIL reset_pre_oper: op_valid=%b want 1", op_valid);
        end
        #2 RST = 1'b1;
        #1;
        a = opA; b = opB;
        checks++;
        if (ew !== 1'b0 || op_valid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b0 ||
            ra !== 5'd0 || rb !== 5'd0 || rw !== 5'd0 || busW !== '0 ||
            a !== '0 || b !== '0 || retire_cnt !== '0) begin
            errors++;
            $display("FAIL reset_async: ew=%b opv=%b busy=%b rr=%b ra=%0d rb=%0d rw=%0d busW=%h opA=%h opB=%h cnt=%0d, want all 0",
                     ew, op_valid, busy, res_ready, ra, rb, rw, busW, a, b, retire_cnt);
        end
        @(negedge CLK) RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: issue_ready=%b want 1", issue_ready);
        end
    endtask

    task automatic test_writeback_read;
        logic [DW-1:0] a, b;
        int unsigned   e, lat;
        logic          to;
        do_instr(5'd1, 5'd2, 5'd5, 1'b1, 32'hDEADBEEF, 0, 0, a, b, e, lat, to);
        checks++;
        if (to || a !== ref_read(5'd1) || b !== ref_read(5'd2)) begin
            errors++; $display("FAIL wb_operands: to=%b opA=%h opB=%h want %h %h", to, a, b, ref_read(5'd1), ref_read(5'd2));
        end
        ref_retire(5'd5, 1'b1, 32'hDEADBEEF);
        checks++;
        if (e != 1 || last_rw !== 5'd5 || last_busW !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wb_write: ew_pulses=%0d rw=%0d busW=%h want 1 5 deadbeef", e, last_rw, last_busW);
        end
        checks++;
        if (lat != 4 || retire_cnt !== CW'(ref_cnt)) begin
            errors++; $display("FAIL wb_latency_cnt: lat=%0d cnt=%0d want 4 %0d", lat, retire_cnt, ref_cnt);
        end
        do_instr(5'd5, 5'd0, 5'd7, 1'b0, 32'h0, 0, 0, a, b, e, lat, to);
        ref_retire(5'd7, 1'b0, 32'h0);
        checks++;
        if (to || a !== 32'hDEADBEEF || b !== 32'h0) begin
            errors++; $display("FAIL read_back: to=%b opA=%h opB=%h want deadbeef 0", to, a, b);
        end
    endtask

    task automatic test_suppress;
        logic [DW-1:0] a, b;
        int unsigned   e, lat;
        logic          to;
        do_instr(5'd2, 5'd3, 5'd0, 1'b1, 32'h1234, 0, 0, a, b, e, lat, to);
        ref_retire(5'd0, 1'b1, 32'h1234);
        checks++;
        if (to || e != 0 || lat != 3 || retire_cnt !== CW'(ref_cnt)) begin
            errors++; $display("FAIL suppress_r0: to=%b ew_pulses=%0d lat=%0d cnt=%0d want 0 3 %0d", to, e, lat, retire_cnt, ref_cnt);
        end
        do_instr(5'd4, 5'd5, 5'd7, 1'b0, 32'h5678, 1, 2, a, b, e, lat, to);
        ref_retire(5'd7, 1'b0, 32'h5678);
        checks++;
        if (to || e != 0 || retire_cnt !== CW'(ref_cnt)) begin
            errors++; $display("FAIL suppress_nowen: to=%b ew_pulses=%0d cnt=%0d want 0 %0d", to, e, retire_cnt, ref_cnt);
        end
    endtask

    task automatic test_backpressure;
        int unsigned   ew0, n;
        logic [DW-1:0] res;
        res = $urandom;
        ew0 = ew_total;
        @(negedge CLK);
        issue_valid = 1'b1; issue_rs = 5'd5; issue_rt = 5'd3; issue_rd = 5'd8; issue_wen = 1'b1;
        @(posedge CLK); #1 issue_valid = 1'b0;
        @(negedge CLK); @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            // A second issue attempt while stalled must be ignored.
            issue_valid = 1'b1; issue_rs = 5'd9; issue_rd = 5'd10;
            checks++;
            if (op_valid !== 1'b1 || opA !== 32'hDEADBEEF || opB !== ref_read(5'd3) || issue_ready !== 1'b0) begin
                errors++; $display("FAIL bp_oper[%0d]: opv=%b opA=%h opB=%h ir=%b want 1 deadbeef %h 0", i, op_valid, opA, opB, issue_ready, ref_read(5'd3));
            end
            @(negedge CLK);
        end
        issue_valid = 1'b0;
        op_ready = 1'b1;
        @(posedge CLK); #1 op_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (res_ready !== 1'b1 || ew !== 1'b0) begin
                errors++; $display("FAIL bp_wait[%0d]: res_ready=%b ew=%b want 1 0", i, res_ready, ew);
            end
        end
        res_valid = 1'b1; res_data = res;
        @(posedge CLK); #1 res_valid = 1'b0;
        n = 0;
        @(negedge CLK);
        while (busy && n < 20) begin @(negedge CLK); n++; end
        ref_retire(5'd8, 1'b1, res);
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || ew_total - ew0 != 1 || last_rw !== 5'd8 || last_busW !== res || retire_cnt !== CW'(ref_cnt)) begin
            errors++; $display("FAIL bp_done: busy=%b ew_pulses=%0d rw=%0d busW=%h cnt=%0d want 0 1 8 %h %0d",
                               busy, ew_total - ew0, last_rw, last_busW, retire_cnt, res, ref_cnt);
        end
    endtask

    task automatic test_reset_wait_res;
        int unsigned ew0;
        ew0 = ew_total;
        @(negedge CLK);
        issue_valid = 1'b1; issue_rs = 5'd1; issue_rt = 5'd2; issue_rd = 5'd9; issue_wen = 1'b1;
        @(posedge CLK); #1 issue_valid = 1'b0;
        @(negedge CLK); @(negedge CLK);
        op_ready = 1'b1;
        @(posedge CLK); #1 op_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (res_ready !== 1'b1) begin
            errors++; $display("FAIL rst_wr_pre: res_ready=%b want 1", res_ready);
        end
        #2 RST = 1'b1;
        @(negedge CLK) RST = 1'b0;
        ref_cnt = 0;
        res_valid = 1'b1; res_data = 32'hCAFE_F00D;
        repeat (2) @(negedge CLK);
        res_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || ew_total != ew0 || retire_cnt !== '0 || res_ready !== 1'b0) begin
            errors++; $display("FAIL rst_wr_post: busy=%b ew_pulses=%0d cnt=%0d rr=%b want 0 0 0 0", busy, ew_total - ew0, retire_cnt, res_ready);
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] a, b, res, ea, eb;
        logic [4:0]    rs, rt, rd;
        logic          wen, to;
        int unsigned   e, lat, ee;
        for (int i = 0; i < 40; i++) begin
            rs = 5'($urandom_range(31)); rt = 5'($urandom_range(31)); rd = 5'($urandom_range(31));
            wen = 1'($urandom_range(1)); res = $urandom;
            ea = ref_read(rs); eb = ref_read(rt);
            do_instr(rs, rt, rd, wen, res, $urandom_range(3), $urandom_range(3), a, b, e, lat, to);
            ref_retire(rd, wen, res);
            ee = (wen && rd != 5'd0) ? 1 : 0;
            checks++;
            if (to || a !== ea || b !== eb || e != ee || retire_cnt !== CW'(ref_cnt) ||
                (ee == 1 && (last_rw !== rd || last_busW !== res))) begin
                errors++;
                $display("FAIL random[%0d]: to=%b opA=%h/%h opB=%h/%h ew=%0d/%0d cnt=%0d/%0d rw=%0d/%0d busW=%h/%h",
                         i, to, a, ea, b, eb, e, ee, retire_cnt, ref_cnt, last_rw, rd, last_busW, res);
            end
        end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] a, b;
        int unsigned   e, lat;
        logic          to;
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK) RST = 1'b0;
        ref_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            do_instr(5'($urandom_range(31)), 5'($urandom_range(31)), 5'd3, 1'b0, $urandom, 0, 0, a, b, e, lat, to);
            ref_retire(5'd3, 1'b0, 32'h0);
            if (i == 14) begin
                checks++;
                if (to || retire_cnt !== 4'd15) begin
                    errors++; $display("FAIL wrap_15: to=%b cnt=%0d want 15", to, retire_cnt);
                end
            end
        end
        checks++;
        if (retire_cnt !== 4'd0 || retire_cnt !== CW'(ref_cnt)) begin
            errors++; $display("FAIL wrap_0: cnt=%0d want 0", retire_cnt);
        end
    endtask

    initial begin
        RST = 1'b1;
        issue_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_rd = '0; issue_wen = 1'b0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h1000_0000 + i * 32'h0101_0101;
        ref_cnt = 0;
        test_reset();
        test_writeback_read();
        test_suppress();
        test_backpressure();
        test_reset_wait_res();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
- Sequencer that owns the access side of the 32x32 MIPS register file (the file's read-address, write-address, write-data and write-enable ports) for the multi-cycle datapath.
- Accepts one instruction's register fields at a time and reads both source operands, forcing $0 to zero.
- Hands the operands to the execute stage, waits for the result, then performs the writeback. Writes to $0 and writes from non-writing instructions are suppressed.

Parameters:
DW, 32, data width of register file buses and operands
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
issue_valid  in  1  instruction fields valid
issue_ready  out  1  controller can accept an instruction
issue_rs  in  5  source register A number
issue_rt  in  5  source register B number
issue_rd  in  5  destination register number
issue_wen  in  1  instruction writes back
ra  out  5  register file read address A
rb  out  5  register file read address B
busA  in  DW  register file read data A (combinational)
busB  in  DW  register file read data B (combinational)
rw  out  5  register file write address
busW  out  DW  register file write data
ew  out  1  register file write enable
op_valid  out  1  operands valid to execute
op_ready  in  1  execute accepts operands
opA  out  DW  operand A
opB  out  DW  operand B
res_valid  in  1  execute result valid
res_ready  out  1  controller accepts result
res_data  in  DW  execute result
retire_cnt  out  CNT_W  completed-instruction count
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, RST=1) puts the controller into state IDLE and forces all outputs low or zero: ra, rb, rw, busW, opA, opB, ew, op_valid, res_ready, retire_cnt and busy.
- In IDLE only, issue_ready is 1. Reset does not touch register file contents.
- States are IDLE, FETCH, OPER, WAIT_RES and WRITE. Every transition happens on the CLK rising edge.
- IDLE:
  - issue_ready=1.
  - On issue_valid: latch rs, rt, rd and wen internally. ra<=issue_rs, rb<=issue_rt. Go to FETCH.
- FETCH:
  - One cycle with ra/rb stable.
  - At the edge: opA<=(ra==0)?0:busA, opB<=(rb==0)?0:busB. Set op_valid<=1. Go to OPER.
  - $0 forcing is independent of what busA/busB return.
- OPER:
  - op_valid=1. opA and opB are held stable.
  - On op_ready: op_valid<=0, res_ready<=1, go to WAIT_RES.
- WAIT_RES:
  - res_ready=1.
  - On res_valid with latched wen=1 and rd!=0: rw<=rd, busW<=res_data, ew<=1, res_ready<=0, go to WRITE.
  - On res_valid otherwise: the result is discarded, retire_cnt increments, res_ready<=0, go to IDLE.
- WRITE:
  - ew=1 for exactly one cycle.
  - At the edge: ew<=0, retire_cnt increments, go to IDLE. rw and busW hold their last value.
- Latency: issue accepted at edge E0 → op_valid high from E1. Minimum time from accept back to IDLE is 4 edges for a writeback and 3 edges for a no-write instruction (op_ready and res_valid high with no waits).
- ew is never asserted outside WRITE. Any write aimed at $0 is suppressed.
- Serial operation: only one instruction is in flight, so no RAW bypass is needed. A write completes before the next issue can be accepted.
- retire_cnt wraps modulo 2^CNT_W.
- Reset mid-operation: the pending instruction and its write are dropped and ew falls immediately. After reset deasserts, a res_valid is ignored and no write occurs.
- Handshakes:
  - Inputs must be stable while valid=1 and ready=0.
  - issue_valid is ignored in any state other than IDLE.
  - A res_valid arriving while in OPER is ignored.

Test Plan:
- Reset: assert RST mid-cycle → ew, op_valid, busy, ra, rb, rw, busW, opA, opB and retire_cnt all 0 without a clock; issue_ready=1 after release.
- Writeback then read:
  - Issue rd=5, wen=1, with op_ready=1, then res_data=0xDEADBEEF → a single ew pulse with rw=5 and busW=0xDEADBEEF, and retire_cnt=1.
  - Then issue rs=5, rt=0 → opA=0xDEADBEEF, opB=0 (even if the model drives busB=0xFFFFFFFF).
- $0 and no-write suppression:
  - Issue rd=0, wen=1 with res 0x1234 → ew never high, retire_cnt increments.
  - Issue rd=7, wen=0 → ew never high.
- Backpressure: hold op_ready=0 for 3 cycles with rs=5 holding 0xDEADBEEF → op_valid and opA stay constant, issue_ready=0, and a second issue_valid is ignored. Then hold res_valid=0 for 2 cycles → res_ready stays 1.
- Reset in WAIT_RES: pulse RST, then drive res_valid=1 with rd=9 → state IDLE, no ew, retire_cnt=0.
- Counter wrap: CNT_W=4, run 16 no-write instructions → retire_cnt reads 15, then 0.
